// File: rtl/vga_timing_monitor_if.sv
// Tap of the VGA output bus: the driver owns it (master), monitors only listen (slave).
interface vga_timing_monitor_if;
    logic       video_hs;
    logic       video_vs;
    logic       video_de;
    logic [5:0] video_rgb;

    modport master (output video_hs, video_vs, video_de, video_rgb);
    modport slave  (input  video_hs, video_vs, video_de, video_rgb);
endinterface

// File: rtl/vga_timing_monitor.sv
// Observe-only VGA timing checker: measures line/frame geometry, locks after two
// conforming frames, counts bad frames and timeouts, and checksums each frame's pixels.
module vga_timing_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                pixel_clk,
    input  logic                sys_rst,
    vga_timing_monitor_if.slave video,
    output logic                locked,
    output logic                frame_done,
    output logic                frame_ok,
    output logic [11:0]         meas_h_total,
    output logic [9:0]          meas_v_total,
    output logic [9:0]          meas_v_active,
    output logic [15:0]         frame_sum,
    output logic [7:0]          err_cnt
);

    localparam logic [19:0] TIMEOUT_LAST = 20'(2 * H_TOTAL * V_TOTAL - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t      state, state_next;
    logic [1:0]  good_cnt, good_next;

    logic        hs_s1, vs_s1, de_s1, hs_s2, vs_s2;
    logic [5:0]  rgb_s1;
    logic [11:0] line_cnt;
    logic [10:0] de_cnt;
    logic [9:0]  v_cnt, act_cnt;
    logic [15:0] sum;
    logic        h_bad, de_bad;
    logic [19:0] tmo_cnt;

    logic        hs_edge, vs_edge;
    logic [11:0] line_len;
    logic [10:0] de_line;
    logic [9:0]  v_total_now, v_active_now;
    logic [15:0] sum_now;
    logic        h_bad_now, de_bad_now, frame_good, timeout;
    logic        check_frame, bad_event;

    assign hs_edge = (hs_s1 == SYNC_POL) && (hs_s2 != SYNC_POL);
    assign vs_edge = (vs_s1 == SYNC_POL) && (vs_s2 != SYNC_POL);

    // "_now" values fold the current cycle in, so a line closing on the vs edge
    // is still counted toward the frame that is ending.
    assign line_len     = (line_cnt == 12'hFFF) ? line_cnt : line_cnt + 12'd1;
    assign de_line      = (de_s1 && de_cnt != 11'h7FF) ? de_cnt + 11'd1 : de_cnt;
    assign sum_now      = de_s1 ? sum + {10'd0, rgb_s1} : sum;
    assign v_total_now  = (hs_edge && v_cnt != 10'h3FF) ? v_cnt + 10'd1 : v_cnt;
    assign v_active_now = (hs_edge && de_line != 11'd0 && act_cnt != 10'h3FF)
                          ? act_cnt + 10'd1 : act_cnt;
    assign h_bad_now    = h_bad || (hs_edge && line_len != 12'(H_TOTAL));
    assign de_bad_now   = de_bad || (hs_edge && de_line != 11'd0 && de_line != 11'(H_ACTIVE));
    assign frame_good   = !h_bad_now && !de_bad_now &&
                          v_total_now == 10'(V_TOTAL) && v_active_now == 10'(V_ACTIVE);
    assign timeout      = (state != SEARCH) && !vs_edge && (tmo_cnt == TIMEOUT_LAST);

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= SEARCH;
            good_cnt <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_next = state;
        good_next  = good_cnt;
        case (state)
            SEARCH: begin
                if (vs_edge) begin
                    state_next = CHECK;
                    good_next  = 2'd0;
                end
            end
            CHECK: begin
                if (vs_edge) begin
                    if (!frame_good) begin
                        good_next = 2'd0;
                    end else if (good_cnt == 2'd1) begin
                        state_next = LOCKED;
                        good_next  = 2'd2;
                    end else begin
                        good_next = good_cnt + 2'd1;
                    end
                end else if (timeout) begin
                    state_next = SEARCH;
                    good_next  = 2'd0;
                end
            end
            LOCKED: begin
                if (vs_edge && !frame_good) begin
                    state_next = CHECK;
                    good_next  = 2'd0;
                end else if (timeout) begin
                    state_next = SEARCH;
                    good_next  = 2'd0;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = 2'd0;
            end
        endcase
    end

    always_comb begin
        check_frame = vs_edge && (state != SEARCH);
        bad_event   = (check_frame && !frame_good) || timeout;
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hs_s1 <= 1'b0; vs_s1 <= 1'b0; de_s1 <= 1'b0; rgb_s1 <= 6'd0;
            hs_s2 <= 1'b0; vs_s2 <= 1'b0;
            line_cnt <= 12'd0; de_cnt <= 11'd0; v_cnt <= 10'd0; act_cnt <= 10'd0;
            sum <= 16'd0; h_bad <= 1'b0; de_bad <= 1'b0; tmo_cnt <= 20'd0;
            locked <= 1'b0; frame_done <= 1'b0; frame_ok <= 1'b0;
            meas_h_total <= 12'd0; meas_v_total <= 10'd0; meas_v_active <= 10'd0;
            frame_sum <= 16'd0; err_cnt <= 8'd0;
        end else begin
            hs_s1  <= video.video_hs;
            vs_s1  <= video.video_vs;
            de_s1  <= video.video_de;
            rgb_s1 <= video.video_rgb;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;

            line_cnt <= hs_edge ? 12'd0 : line_len;
            de_cnt   <= hs_edge ? 11'd0 : de_line;
            if (hs_edge) meas_h_total <= line_len;

            v_cnt   <= vs_edge ? 10'd0 : v_total_now;
            act_cnt <= vs_edge ? 10'd0 : v_active_now;
            sum     <= vs_edge ? 16'd0 : sum_now;
            h_bad   <= vs_edge ? 1'b0  : h_bad_now;
            de_bad  <= vs_edge ? 1'b0  : de_bad_now;
            tmo_cnt <= (vs_edge || timeout || state == SEARCH) ? 20'd0 : tmo_cnt + 20'd1;

            if (vs_edge) begin
                meas_v_total  <= v_total_now;
                meas_v_active <= v_active_now;
                frame_sum     <= sum_now;
            end
            frame_done <= check_frame;
            if (check_frame) frame_ok <= frame_good;
            if (bad_event && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            locked <= (state_next == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a shrunken 16x10 raster so every scenario,
// including timeout and err_cnt saturation, runs in a few thousand cycles.
module tb_vga_timing_monitor;

  localparam int HT = 16, HA = 10, VT = 10, VA = 6;
  localparam bit POL = 1'b0;
  localparam int TMO = 2 * HT * VT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_timing_monitor_if vif ();

  logic        locked, frame_done, frame_ok;
  logic [11:0] meas_h_total;
  logic [9:0]  meas_v_total, meas_v_active;
  logic [15:0] frame_sum;
  logic [7:0]  err_cnt;

  vga_timing_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(POL)
  ) dut (
    .pixel_clk    (clk),
    .sys_rst      (rst),
    .video        (vif),
    .locked       (locked),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .meas_h_total (meas_h_total),
    .meas_v_total (meas_v_total),
    .meas_v_active(meas_v_active),
    .frame_sum    (frame_sum),
    .err_cnt      (err_cnt)
  );

  int n_vec = 0, n_bad = 0, done_cnt = 0, seed = 0;
  bit chk_en = 1'b0, saw_h17 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: works on the sampled input stream with sample indices and
  // plain integers; its results appear on the DUT one clock after the sample.
  typedef struct { bit locked; bit done; bit ok; int h; int vt; int va; int sum; int err; } exp_t;
  typedef enum {M_SEARCH, M_CHECK, M_LOCKED} mode_t;
  exp_t  e_cur, e_q;
  mode_t mode;
  int    good_run, n, last_hs, last_vs, lines, vact, de_line, psum;
  bit    hbad, debad;
  logic  hs_prev, vs_prev;

  task automatic model_reset();
    e_cur = '{default: 0};
    e_q   = e_cur;
    mode = M_SEARCH; good_run = 0; n = 0; last_hs = -1; last_vs = 0;
    lines = 0; vact = 0; de_line = 0; psum = 0; hbad = 0; debad = 0;
    hs_prev = 1'b0; vs_prev = 1'b0;
  endtask

  task automatic model_step(input logic hs, input logic vs, input logic de, input logic [5:0] rgb);
    bit hs_e, vs_e, good;
    n++;
    hs_e = (hs == POL) && (hs_prev != POL);
    vs_e = (vs == POL) && (vs_prev != POL);
    hs_prev = hs; vs_prev = vs;
    if (de) begin
      if (de_line < 2047) de_line++;
      psum = (psum + int'(rgb)) % 65536;
    end
    e_cur.done = 0;
    if (hs_e) begin
      e_cur.h = (n - last_hs > 4095) ? 4095 : n - last_hs;
      last_hs = n;
      if (e_cur.h != HT) hbad = 1;
      if (de_line > 0) begin
        if (vact < 1023) vact++;
        if (de_line != HA) debad = 1;
      end
      de_line = 0;
      if (lines < 1023) lines++;
    end
    if (vs_e) begin
      good = !hbad && !debad && lines == VT && vact == VA;
      e_cur.vt = lines; e_cur.va = vact; e_cur.sum = psum;
      if (mode == M_SEARCH) begin
        mode = M_CHECK; good_run = 0;
      end else begin
        e_cur.done = 1; e_cur.ok = good;
        if (good) begin
          good_run++;
          if (good_run >= 2) mode = M_LOCKED;
        end else begin
          mode = M_CHECK; good_run = 0;
          if (e_cur.err < 255) e_cur.err++;
        end
      end
      lines = 0; vact = 0; psum = 0; hbad = 0; debad = 0; last_vs = n;
    end else if (mode != M_SEARCH && n - last_vs == TMO) begin
      mode = M_SEARCH; good_run = 0;
      if (e_cur.err < 255) e_cur.err++;
    end
    e_cur.locked = (mode == M_LOCKED);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      e_q = e_cur;
      model_step(vif.video_hs, vif.video_vs, vif.video_de, vif.video_rgb);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",        locked,        e_q.locked);
      check("frame_done",    frame_done,    e_q.done);
      check("frame_ok",      frame_ok,      e_q.ok);
      check("meas_h_total",  meas_h_total,  e_q.h);
      check("meas_v_total",  meas_v_total,  e_q.vt);
      check("meas_v_active", meas_v_active, e_q.va);
      check("frame_sum",     frame_sum,     e_q.sum);
      check("err_cnt",       err_cnt,       e_q.err);
      if (frame_done === 1'b1) done_cnt++;
      if (meas_h_total === 12'd17) saw_h17 = 1'b1;
    end
  end

  task automatic tick(input bit hs_a, input bit vs_a, input bit de, input logic [5:0] rgb);
    vif.video_hs  = hs_a ? POL : ~POL;
    vif.video_vs  = vs_a ? POL : ~POL;
    vif.video_de  = de;
    vif.video_rgb = de ? rgb : 6'd0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  // Line: 2 sync, 2 back porch, HA active, rest front porch. Active lines 3..3+VA-1.
  task automatic frame(input int nlines, input int first_line, input int stretch, input int short_de,
                       input bit vs_late, input bit vs_off, input bit rgb_one);
    seed++;
    for (int l = first_line; l < nlines; l++) begin
      int len, de_n;
      len  = (l == stretch) ? HT + 1 : HT;
      de_n = (l == short_de) ? HA - 1 : HA;
      for (int c = 0; c < len; c++) begin
        bit vs_a, de;
        logic [5:0] rgb;
        vs_a = vs_late ? ((l == 0 && c >= 1) || l == 1 || (l == 2 && c < 1)) : (l < 2);
        de   = (l >= 3) && (l < 3 + VA) && (c >= 4) && (c < 4 + de_n);
        rgb  = rgb_one ? 6'd1 : 6'((l * 5 + c * 3 + seed) & 63);
        tick(c < 2, vs_a && !vs_off, de, rgb);
      end
    end
  endtask

  task automatic zero_checks(input string pfx);
    check({pfx, "_locked"},  locked,        0);
    check({pfx, "_done"},    frame_done,    0);
    check({pfx, "_ok"},      frame_ok,      0);
    check({pfx, "_h"},       meas_h_total,  0);
    check({pfx, "_vt"},      meas_v_total,  0);
    check({pfx, "_va"},      meas_v_active, 0);
    check({pfx, "_sum"},     frame_sum,     0);
    check({pfx, "_err"},     err_cnt,       0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1;
    vif.video_hs = ~POL; vif.video_vs = ~POL; vif.video_de = 1'b0; vif.video_rgb = 6'd0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    zero_checks("reset");
    rst = 1'b0;
    idle(4);

    // Nominal raster, constant rgb: third vs edge locks, sum = 6 lines * 10 px * 1.
    repeat (3) frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b1);
    check("nom_locked", locked, 1);
    check("nom_h", meas_h_total, 16);
    check("nom_vt", meas_v_total, 10);
    check("nom_va", meas_v_active, 6);
    check("nom_sum", frame_sum, 60);
    check("nom_ok", frame_ok, 1);
    check("nom_err", err_cnt, 0);
    check("nom_done_pulses", done_cnt, 2);

    // One line short by a DE cycle.
    frame(VT, 0, -1, 5, 1'b0, 1'b0, 1'b0);
    frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("de_ok", frame_ok, 0);
    check("de_locked", locked, 0);
    check("de_err", err_cnt, 1);
    repeat (2) frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("de_relock", locked, 1);

    // vs one cycle after hs, then back to coincident.
    repeat (2) frame(VT, 0, -1, -1, 1'b1, 1'b0, 1'b0);
    check("late_vt", meas_v_total, 10);
    check("late_ok", frame_ok, 1);
    check("late_locked", locked, 1);
    frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("realign_locked", locked, 1);

    // One stretched line in an 11-line frame.
    frame(VT + 1, 0, 4, -1, 1'b0, 1'b0, 1'b0);
    frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("str_saw_h17", saw_h17, 1);
    check("str_vt", meas_v_total, 11);
    check("str_ok", frame_ok, 0);
    check("str_err", err_cnt, 2);
    repeat (2) frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("str_relock", locked, 1);

    // vs stuck deasserted past the timeout.
    frame(25, 0, -1, -1, 1'b0, 1'b1, 1'b0);
    check("tmo_locked", locked, 0);
    check("tmo_err", err_cnt, 3);
    d0 = done_cnt;
    frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("tmo_no_done", done_cnt - d0, 0);
    repeat (2) frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("tmo_relock", locked, 1);

    // Reset mid-frame while locked.
    frame(5, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("prerst_locked", locked, 1);
    #2 rst = 1'b1;
    #1 zero_checks("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    frame(VT, 5, -1, -1, 1'b0, 1'b0, 1'b0);
    repeat (3) frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("rst_relock", locked, 1);
    check("rst_err", err_cnt, 0);

    // Error counter saturation with back-to-back 3-line frames.
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    repeat (260) frame(3, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    frame(VT, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    check("sat_err", err_cnt, 255);
    check("sat_done_pulses", done_cnt - d0, 261);
    check("sat_locked", locked, 0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
